// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset release sequencer.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      WAIT_ACK = 2'd1,
      DONE     = 2'd2,
      ERROR    = 2'd3
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases NumStages reset domains in index order, waiting for each domain's
// ack before spacing out the next release; flags stages that never respond.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NumStages     = 4,
   parameter int DelayCycles   = 16,
   parameter int TimeoutCycles = 1024,
   localparam int CntWidth     = $clog2(max_int(DelayCycles, TimeoutCycles) + 1),
   localparam int IdxWidth     = (NumStages > 1) ? $clog2(NumStages) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 test_mode_i,
   input  logic                 soft_req_i,
   input  logic [NumStages-1:0] ack_i,
   output logic [NumStages-1:0] rst_no,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic [IdxWidth-1:0]  err_stage_o
);

   localparam logic [CntWidth-1:0] DelayLast   = CntWidth'(DelayCycles - 1);
   localparam logic [CntWidth-1:0] TimeoutLast =
      CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
   localparam logic [CntWidth-1:0] CntMax      = '1;
   localparam logic [IdxWidth-1:0] LastIdx     = IdxWidth'(NumStages - 1);
   localparam bit                  TimeoutOn   = (TimeoutCycles != 0);

   state_e                 state_q, state_d;
   logic [CntWidth-1:0]    cnt_q, cnt_d;
   logic [IdxWidth-1:0]    idx_q, idx_d;
   logic [NumStages-1:0]   rst_no_q, rst_no_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;
   logic [IdxWidth-1:0]    err_stage_q, err_stage_d;

   // Saturating increment: the counter parks at all-ones instead of wrapping.
   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
      return (c == CntMax) ? c : c + CntWidth'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rst_no_d    = rst_no_q;
      busy_d      = busy_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      err_stage_d = err_stage_q;

      unique case (state_q)
         HOLD: begin
            if (cnt_q == DelayLast) begin
               rst_no_d[idx_q] = 1'b1;
               cnt_d           = '0;
               state_d         = WAIT_ACK;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         WAIT_ACK: begin
            // Ack is checked before expiry so a same-cycle ack always wins.
            if (ack_i[idx_q]) begin
               if (idx_q == LastIdx) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + IdxWidth'(1);
                  cnt_d   = '0;
                  state_d = HOLD;
               end
            end else if (TimeoutOn && (cnt_q == TimeoutLast)) begin
               state_d     = ERROR;
               busy_d      = 1'b0;
               timeout_d   = 1'b1;
               err_stage_d = idx_q;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         DONE, ERROR: begin
            state_d = state_q;
         end
         default: begin
            state_d = HOLD;
         end
      endcase

      if (soft_req_i && !test_mode_i) begin
         state_d     = HOLD;
         cnt_d       = '0;
         idx_d       = '0;
         rst_no_d    = '0;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         timeout_d   = 1'b0;
         err_stage_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_no_q    <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_stage_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rst_no_q    <= rst_no_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         err_stage_q <= err_stage_d;
      end
   end

   // Test mode hands the raw reset straight through; the FSM stays hidden.
   assign rst_no      = test_mode_i ? {NumStages{rst_ni}} : rst_no_q;
   assign busy_o      = test_mode_i ? 1'b0   : busy_q;
   assign done_o      = test_mode_i ? rst_ni : done_q;
   assign timeout_o   = test_mode_i ? 1'b0   : timeout_q;
   assign err_stage_o = test_mode_i ? '0     : err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboarded random/directed bench for reset_sequencer against an
// event-count reference model (released stages, acked stages, elapsed edges).
module tb_reset_sequencer;

   localparam int N  = 4;
   localparam int D  = 16;
   localparam int TO = 8;

   logic         clk_i;
   logic         rst_ni;
   logic         test_mode_i;
   logic         soft_req_i;
   logic [N-1:0] ack_i;
   logic [N-1:0] rst_no;
   logic         busy_o;
   logic         done_o;
   logic         timeout_o;
   logic [1:0]   err_stage_o;

   reset_sequencer #(
      .NumStages    (N),
      .DelayCycles  (D),
      .TimeoutCycles(TO)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .test_mode_i(test_mode_i),
      .soft_req_i (soft_req_i),
      .ack_i      (ack_i),
      .rst_no     (rst_no),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .timeout_o  (timeout_o),
      .err_stage_o(err_stage_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      logic [N-1:0] rst_no;
      logic         busy;
      logic         done;
      logic         tmo;
      logic [1:0]   es;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: counts of released and acknowledged stages plus the
   // number of edges spent in the current gap or wait.
   int m_nrel = 0, m_nack = 0, m_t = 0;
   bit m_err  = 1'b0;
   int age[N];
   int lag[N];
   int ack_mode = 0;
   logic drv_rst = 1'b0, drv_tm = 1'b0, drv_soft = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   always @(posedge clk_i) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("rst_no",      32'(rst_no),      32'(e.rst_no));
         check("busy_o",      32'(busy_o),      32'(e.busy));
         check("done_o",      32'(done_o),      32'(e.done));
         check("timeout_o",   32'(timeout_o),   32'(e.tmo));
         check("err_stage_o", 32'(err_stage_o), 32'(e.es));
      end
   end

   task automatic model_edge(input logic r, input logic tm, input logic sf, input logic [N-1:0] a);
      if (!r || (sf && !tm)) begin
         m_nrel = 0; m_nack = 0; m_t = 0; m_err = 1'b0;
      end else if (m_err || m_nack == N) begin
         // terminal until restart
      end else if (m_nrel == m_nack) begin
         m_t++;
         if (m_t == D) begin
            m_nrel++;
            m_t = 0;
         end
      end else if (a[m_nack]) begin
         m_nack++;
         m_t = 0;
      end else if (TO != 0 && m_t + 1 == TO) begin
         m_err = 1'b1;
      end else begin
         m_t++;
      end
   endtask

   task automatic step();
      logic [N-1:0] a;
      int           prev_nrel;
      exp_t         e;
      for (int k = 0; k < N; k++) if (m_nrel > k) age[k]++;
      for (int k = 0; k < N; k++) begin
         case (ack_mode)
            0:       a[k] = (m_nrel > k) && (lag[k] >= 0) && (age[k] >= lag[k]);
            1:       a[k] = 1'($urandom);
            2:       a[k] = 1'b1;
            default: a[k] = 1'b0;
         endcase
      end
      rst_ni      = drv_rst;
      test_mode_i = drv_tm;
      soft_req_i  = drv_soft;
      ack_i       = a;
      prev_nrel   = m_nrel;
      model_edge(drv_rst, drv_tm, drv_soft, a);
      for (int k = 0; k < N; k++) if (k >= prev_nrel || k >= m_nrel) age[k] = 0;
      if (drv_tm) begin
         e.rst_no = {N{drv_rst}};
         e.busy   = 1'b0;
         e.done   = drv_rst;
         e.tmo    = 1'b0;
         e.es     = '0;
      end else begin
         e.rst_no = N'((1 << m_nrel) - 1);
         e.busy   = !m_err && (m_nack < N);
         e.done   = (m_nack == N);
         e.tmo    = m_err;
         e.es     = m_err ? 2'(m_nack) : 2'd0;
      end
      exp_q.push_back(e);
      @(negedge clk_i);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_soft();
      drv_soft = 1'b1;
      step();
      drv_soft = 1'b0;
   endtask

   task automatic run_until_wait(input int k, input int max_cyc);
      int c = 0;
      while (!(m_nrel == k + 1 && m_nack == k && !m_err) && c < max_cyc) begin
         step();
         c++;
      end
      if (c == max_cyc) begin
         failures++;
         $display("FAIL reach_wait_stage%0d: not reached within %0d cycles", k, max_cyc);
      end
   endtask

   task automatic set_lags(input int l0, input int l1, input int l2, input int l3);
      lag[0] = l0; lag[1] = l1; lag[2] = l2; lag[3] = l3;
   endtask

   initial begin
      for (int k = 0; k < N; k++) age[k] = 0;
      set_lags(3, 3, 3, 3);
      rst_ni = 1'b0; test_mode_i = 1'b0; soft_req_i = 1'b0; ack_i = '0;

      // Reset, then the nominal full sequence through DONE.
      drv_rst = 1'b0; run(3);
      drv_rst = 1'b1; run(100);

      // Soft restart from DONE, then again while stage 1 awaits its ack.
      pulse_soft();
      set_lags(3, 6, 3, 3);
      run_until_wait(1, 200);
      run(2);
      pulse_soft();
      run(100);

      // Stage 2 never acknowledges: timeout with err_stage 2.
      set_lags(3, 3, -1, 3);
      pulse_soft();
      run(80);

      // Ack arriving exactly on the expiry edge, and ack high at release.
      set_lags(3, TO, 0, TO + 1);
      pulse_soft();
      run(100);
      ack_mode = 2;
      pulse_soft();
      run(80);
      ack_mode = 0;

      // Reset mid-sequence, and reset together with a soft request.
      set_lags(3, 3, 3, 3);
      pulse_soft();
      run(30);
      drv_rst = 1'b0; run(1);
      drv_rst = 1'b1; run(25);
      drv_rst = 1'b0; drv_soft = 1'b1; run(1);
      drv_rst = 1'b1; drv_soft = 1'b0; run(100);

      // Test mode bypass with no acks, tracking a toggling reset.
      ack_mode = 3;
      drv_tm = 1'b1;
      for (int i = 0; i < 60; i++) begin
         drv_rst = (i % 7 != 3);
         step();
      end
      drv_rst = 1'b1; run(30);
      drv_tm = 1'b0; run(5);
      ack_mode = 0;

      // Randomized episodes.
      for (int ep = 0; ep < 30; ep++) begin
         bit tm_ep;
         for (int k = 0; k < N; k++)
            lag[k] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 2));
         ack_mode = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
         tm_ep    = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < 150; i++) begin
            drv_tm   = tm_ep;
            drv_rst  = ($urandom_range(0, 149) != 0);
            drv_soft = !tm_ep && ($urandom_range(0, 99) == 0);
            step();
         end
         drv_tm = 1'b0; drv_soft = 1'b0; drv_rst = 1'b1;
         step();
      end

      @(posedge clk_i);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Downstream consumer of the synchronized reset produced by the reset generator.
- Releases NumStages reset domains one at a time, in index order (0 first).
- After releasing a domain, waits for that domain's ready acknowledge before it releases the next one.
- Inserts a programmable gap between releases, detects stages that never acknowledge (timeout), and supports software-requested re-sequencing. Sits between the reset generator and the per-subsystem reset inputs.

Parameters:
- NumStages, 4, number of sequenced reset outputs (>=1).
- DelayCycles, 16, hold/gap cycles before each stage release (>=1).
- TimeoutCycles, 1024, maximum wait for ack_i[k]; 0 disables the timeout.
- CntWidth, derived: $clog2(max(DelayCycles, TimeoutCycles)+1), counter width (localparam).
- IdxWidth, derived: max(1, $clog2(NumStages)), stage index width (localparam).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low (driven from the reset generator's rst_no).
- test_mode_i  in  1  bypass: all rst_no follow rst_ni; ack and timeout are ignored.
- soft_req_i  in  1  single-cycle request to restart the whole sequence.
- ack_i  in  NumStages  per-stage ready; level, synchronous to clk_i.
- rst_no  out  NumStages  per-stage active-low reset.
- busy_o  out  1  sequence in progress.
- done_o  out  1  all stages released and acknowledged.
- timeout_o  out  1  a stage failed to acknowledge in time.
- err_stage_o  out  IdxWidth  index of the stage that timed out.

Behaviour:
- Reset (rst_ni=0 sampled at a clk_i edge):
  - State=HOLD, cnt=0, idx=0.
  - rst_no=0, busy_o=1, done_o=0, timeout_o=0, err_stage_o=0.
- All outputs are registered, except in test mode (see below).
- HOLD:
  - cnt increments each cycle.
  - At cnt==DelayCycles-1: set rst_no[idx]=1, clear cnt, go to WAIT_ACK.
  - Net timing: rst_no[0] rises exactly DelayCycles edges after the first edge with rst_ni=1.
- WAIT_ACK:
  - cnt increments each cycle.
  - If ack_i[idx]=1 and idx==NumStages-1: go to DONE.
  - If ack_i[idx]=1 and idx<NumStages-1: idx++, clear cnt, go to HOLD. HOLD then acts as the inter-stage gap.
  - Else, if TimeoutCycles!=0 and cnt==TimeoutCycles-1: go to ERROR, timeout_o=1, err_stage_o=idx.
  - If ack and timeout occur in the same cycle, ack wins.
  - ack_i bits other than idx are ignored.
  - An ack that is already high at release is accepted on the first WAIT_ACK cycle.
- DONE:
  - busy_o=0, done_o=1; all rst_no stay 1.
  - A later deassertion of ack_i is ignored.
- ERROR:
  - busy_o=0, done_o=0, timeout_o=1.
  - Released stages stay released; unreleased stages stay in reset.
  - Terminal until soft_req_i or reset.
- soft_req_i=1 (any state, non-test mode):
  - Next cycle: rst_no=0, idx=0, cnt=0, state=HOLD, busy_o=1, done_o=0, timeout_o=0, err_stage_o=0.
  - During a sequence this aborts and restarts it.
  - rst_ni=0 has priority over soft_req_i.
- Released stages only ever drop again through reset or soft_req_i; no glitching on rst_no.
- Test mode (combinational bypass):
  - rst_no = {NumStages{rst_ni}}, done_o=rst_ni, busy_o=0, timeout_o=0.
  - The internal FSM keeps running but is not observable.
- Counter saturates; it never wraps in any state.

Decomposition:
- Package reset_sequencer_pkg holds state_e (HOLD, WAIT_ACK, DONE, ERROR; 2-bit encoding).
- No sub-module; the counter is inline.

Test Plan:
- Default params; rst_ni high at cycle 0; each ack_i[k] rises 3 cycles after rst_no[k] rises -> rst_no[0] rises at cycle 16, then each later stage rises 16 cycles after the previous stage's ack. done_o=1 once ack_i[3] is seen.
- TimeoutCycles=8; ack_i[2] held 0 -> 8 cycles after rst_no[2] rises: timeout_o=1, err_stage_o=2, rst_no=4'b0111, busy_o=0, done_o=0.
- soft_req_i pulsed in DONE and again mid-WAIT_ACK of stage 1 -> next cycle rst_no=0, busy_o=1. rst_no[0] re-rises 16 cycles after the pulse.
- ack_i[idx] rises in the same cycle as the timeout expiry -> sequence advances, timeout_o stays 0.
- rst_ni driven low mid-sequence and also low in the same cycle as soft_req_i -> all outputs take reset values on the next edge. Sequence restarts from stage 0 once rst_ni returns high.
- test_mode_i=1, ack_i=0 -> rst_no tracks rst_ni combinationally; timeout_o=0 indefinitely.
